// File: rtl/spy_serial_port.sv
`timescale 1ns/1ps
// spy_serial_port
//   Debug bridge between a host UART link and a 16-bit spy register bus.
//   Each 8N1 command byte received on rs232_rxd either loads one nibble of the
//   write-data register, issues a bus write, or issues a bus read. A read
//   returns the captured 16-bit word as four serial bytes 0x3d,0x4d,0x5d,0x6d,
//   one for each nibble d, least significant nibble first.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   rs232_rxd  serial input (idle high, asynchronous)
//   spy_in     bus read data, captured at the end of the read strobe
//   rs232_txd  serial output (idle high)
//   spy_out    bus write data register
//   eadr       bus register address
//   dbread     read strobe (2 clocks)
//   dbwrite    write strobe (1 clock)
//
// Transmitter load handshake: the command FSM drives ld_tx_req together with
// tx_data. When the transmitter is idle and sees ld_tx_req it latches tx_data
// and pulses ld_tx_ack for one clock. The FSM drops ld_tx_req in the cycle it
// sees ld_tx_ack, so every byte needs a fresh request.
module spy_serial_port #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rs232_rxd,
  input  logic [15:0] spy_in,
  output logic        rs232_txd,
  output logic [15:0] spy_out,
  output logic [4:0]  eadr,
  output logic        dbread,
  output logic        dbwrite
);

  localparam int BIT_CLKS  = CLK_HZ / BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CW        = $clog2(BIT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLKS - 1);

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  rx_state_e       rx_state_q, rx_state_d;
  logic            rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_pend_q, rx_pend_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_take;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_pend_d  = rx_pend_q;
    rx_byte_d  = rx_byte_q;

    // The FSM only takes a byte while one is pending, and a new byte is only
    // stored while none is pending, so the two never collide.
    if (rx_take) begin
      rx_pend_d = 1'b0;
    end

    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_s3_q && !rxd_s2_q) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // A start bit that is no longer low at mid-bit was a glitch.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        // Back to idle at mid stop bit so a following start edge is not missed.
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rxd_s2_q && !rx_pend_q) begin
            rx_pend_d = 1'b1;
            rx_byte_d = rx_shift_q;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_s3_q   <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_pend_q  <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      rxd_s1_q   <= rs232_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_s3_q   <= rxd_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_pend_q  <= rx_pend_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  logic            tx_busy_q, tx_busy_d;
  logic [9:0]      tx_frame_q, tx_frame_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [3:0]      tx_bit_nxt;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic            txd_q, txd_d;
  logic            ld_tx_ack_q, ld_tx_ack_d;
  logic            ld_tx_req_q, ld_tx_req_d;
  logic [7:0]      tx_data;

  assign tx_bit_nxt = tx_bit_q + 4'd1;

  always_comb begin
    tx_busy_d   = tx_busy_q;
    tx_frame_d  = tx_frame_q;
    tx_bit_d    = tx_bit_q;
    tx_cnt_d    = tx_cnt_q + CW'(1);
    txd_d       = txd_q;
    ld_tx_ack_d = 1'b0;

    if (!tx_busy_q) begin
      tx_cnt_d = '0;
      txd_d    = 1'b1;
      if (ld_tx_req_q) begin
        // Frame is stop, data LSB first, start; bit 0 goes out right away.
        tx_busy_d   = 1'b1;
        tx_frame_d  = {1'b1, tx_data, 1'b0};
        tx_bit_d    = '0;
        txd_d       = 1'b0;
        ld_tx_ack_d = 1'b1;
      end
    end else if (tx_cnt_q == BIT_LAST) begin
      tx_cnt_d = '0;
      if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
        txd_d     = 1'b1;
      end else begin
        tx_bit_d = tx_bit_nxt;
        txd_d    = tx_frame_q[tx_bit_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_busy_q   <= 1'b0;
      tx_frame_q  <= '1;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
      txd_q       <= 1'b1;
      ld_tx_ack_q <= 1'b0;
    end else begin
      tx_busy_q   <= tx_busy_d;
      tx_frame_q  <= tx_frame_d;
      tx_bit_q    <= tx_bit_d;
      tx_cnt_q    <= tx_cnt_d;
      txd_q       <= txd_d;
      ld_tx_ack_q <= ld_tx_ack_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_IDLE,
    S_DECODE,
    S_WRITE,
    S_READ1,
    S_READ2,
    S_TX0,
    S_TX1,
    S_TX2,
    S_TX3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic [15:0] spy_out_q, spy_out_d;
  logic [4:0]  eadr_q, eadr_d;
  logic        dbread_q, dbread_d;
  logic        dbwrite_q, dbwrite_d;

  always_comb begin
    case (state_q)
      S_TX1:   tx_data = {4'h4, data_q[7:4]};
      S_TX2:   tx_data = {4'h5, data_q[11:8]};
      S_TX3:   tx_data = {4'h6, data_q[15:12]};
      default: tx_data = {4'h3, data_q[3:0]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    spy_out_d   = spy_out_q;
    eadr_d      = eadr_q;
    dbread_d    = 1'b0;
    dbwrite_d   = 1'b0;
    ld_tx_req_d = 1'b0;
    rx_take     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_pend_q) begin
          rx_take = 1'b1;
          cmd_d   = rx_byte_q;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        case (cmd_q[7:4])
          4'h3: spy_out_d[3:0]   = cmd_q[3:0];
          4'h4: spy_out_d[7:4]   = cmd_q[3:0];
          4'h5: spy_out_d[11:8]  = cmd_q[3:0];
          4'h6: spy_out_d[15:12] = cmd_q[3:0];
          // Op bit 0 selects the upper half of the address space.
          4'h8, 4'h9: begin
            eadr_d   = {cmd_q[4], cmd_q[3:0]};
            dbread_d = 1'b1;
            state_d  = S_READ1;
          end
          4'hA, 4'hB: begin
            eadr_d    = {cmd_q[4], cmd_q[3:0]};
            dbwrite_d = 1'b1;
            state_d   = S_WRITE;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_WRITE: state_d = S_IDLE;
      S_READ1: begin
        dbread_d = 1'b1;
        state_d  = S_READ2;
      end
      S_READ2: begin
        data_d  = spy_in;
        state_d = S_TX0;
      end
      S_TX0, S_TX1, S_TX2, S_TX3: begin
        if (ld_tx_ack_q) begin
          case (state_q)
            S_TX0:   state_d = S_TX1;
            S_TX1:   state_d = S_TX2;
            S_TX2:   state_d = S_TX3;
            default: state_d = S_IDLE;
          endcase
        end else begin
          ld_tx_req_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      data_q      <= '0;
      spy_out_q   <= '0;
      eadr_q      <= '0;
      dbread_q    <= 1'b0;
      dbwrite_q   <= 1'b0;
      ld_tx_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      spy_out_q   <= spy_out_d;
      eadr_q      <= eadr_d;
      dbread_q    <= dbread_d;
      dbwrite_q   <= dbwrite_d;
      ld_tx_req_q <= ld_tx_req_d;
    end
  end

  assign rs232_txd = txd_q;
  assign spy_out   = spy_out_q;
  assign eadr      = eadr_q;
  assign dbread    = dbread_q;
  assign dbwrite   = dbwrite_q;

endmodule

// File: tb/tb_spy_serial_port.sv
`timescale 1ns/1ps
// Bench for spy_serial_port: drives serial commands, decodes the serial
// response, watches the bus strobes and compares everything against a
// command-level model of the bridge.
module tb_spy_serial_port;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int BIT    = CLK_HZ / BAUD;   // clocks per bit
  localparam int CLK_NS = 10;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rs232_rxd = 1'b1;
  logic [15:0] spy_in;
  logic rs232_txd;
  logic [15:0] spy_out;
  logic [4:0] eadr;
  logic dbread;
  logic dbwrite;

  always #(CLK_NS / 2) clk = ~clk;

  spy_serial_port #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .reset     (reset),
    .rs232_rxd (rs232_rxd),
    .spy_in    (spy_in),
    .rs232_txd (rs232_txd),
    .spy_out   (spy_out),
    .eadr      (eadr),
    .dbread    (dbread),
    .dbwrite   (dbwrite)
  );

  // register file seen by the bridge
  logic [15:0] mem [32];
  assign spy_in = mem[eadr];

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [7:0]  exp_q[$];
  logic [20:0] exp_w_q[$];
  logic [4:0]  exp_r_q[$];
  int n_tx_extra = 0;
  int n_wr_extra = 0;
  int n_rd_extra = 0;
  bit tx_abort = 1'b0;
  logic [15:0] m_spy = '0;
  logic [4:0]  m_eadr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // model: what one command byte must cause
  task automatic model_cmd(input logic [7:0] b);
    logic [15:0] d;
    case (b[7:4])
      4'h3: m_spy[3:0]   = b[3:0];
      4'h4: m_spy[7:4]   = b[3:0];
      4'h5: m_spy[11:8]  = b[3:0];
      4'h6: m_spy[15:12] = b[3:0];
      4'h8, 4'h9: begin
        m_eadr = {b[4], b[3:0]};
        d = mem[m_eadr];
        exp_r_q.push_back(m_eadr);
        exp_q.push_back({4'h3, d[3:0]});
        exp_q.push_back({4'h4, d[7:4]});
        exp_q.push_back({4'h5, d[11:8]});
        exp_q.push_back({4'h6, d[15:12]});
      end
      4'hA, 4'hB: begin
        m_eadr = {b[4], b[3:0]};
        exp_w_q.push_back({m_eadr, m_spy});
      end
      default: ;
    endcase
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rs232_rxd = 1'b0;
    #(BIT * CLK_NS);
    for (int i = 0; i < 8; i++) begin
      rs232_rxd = b[i];
      #(BIT * CLK_NS);
    end
    rs232_rxd = stop_bit;
    #(BIT * CLK_NS);
    if (!stop_bit) begin
      rs232_rxd = 1'b1;
      #(BIT * CLK_NS);
    end
    rs232_rxd = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    model_cmd(b);
    send_byte(b, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() + exp_w_q.size() + exp_r_q.size()) != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_left"}, exp_q.size() + exp_w_q.size() + exp_r_q.size(), 0);
    repeat (2 * BIT) @(negedge clk);
    chk({tag, "_eadr"}, eadr, m_eadr);
    chk({tag, "_spy_out"}, spy_out, m_spy);
    chk({tag, "_txd"}, rs232_txd, 1'b1);
    chk({tag, "_tx_extra"}, n_tx_extra, 0);
    chk({tag, "_wr_extra"}, n_wr_extra, 0);
    chk({tag, "_rd_extra"}, n_rd_extra, 0);
  endtask

  // serial response monitor
  initial begin
    logic [7:0] b;
    logic ok;
    forever begin
      @(negedge clk);
      if (rs232_txd === 1'b0) begin
        tx_abort = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        ok = (rs232_txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = rs232_txd;
        end
        repeat (BIT) @(negedge clk);
        ok = ok & (rs232_txd === 1'b1);
        if (!tx_abort) begin
          chk("tx_frame", ok, 1'b1);
          if (exp_q.size() != 0) chk("tx_byte", b, exp_q.pop_front());
          else n_tx_extra++;
        end
      end
    end
  end

  // bus strobe monitor
  initial begin
    int rd_len;
    int wr_len;
    rd_len = 0;
    wr_len = 0;
    forever begin
      @(negedge clk);
      if (dbwrite === 1'b1) begin
        chk("rw_excl", dbread, 1'b0);
        if (wr_len == 0) begin
          if (exp_w_q.size() != 0) chk("wr_addr_data", {eadr, spy_out}, exp_w_q.pop_front());
          else n_wr_extra++;
        end
        wr_len++;
      end else if (wr_len != 0) begin
        chk("wr_len", wr_len, 1);
        wr_len = 0;
      end
      if (dbread === 1'b1) begin
        if (rd_len == 0) begin
          if (exp_r_q.size() != 0) chk("rd_addr", eadr, exp_r_q.pop_front());
          else n_rd_extra++;
        end
        rd_len++;
      end else if (rd_len != 0) begin
        chk("rd_len", rd_len, 2);
        rd_len = 0;
      end
    end
  end

  // main sequence
  initial begin
    logic [7:0] b;
    logic [3:0] ign_ops [8];
    int n;
    int r;
    ign_ops = '{4'h0, 4'h1, 4'h2, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    mem[0]  = 16'h8000;
    mem[1]  = 16'h8001;
    mem[18] = 16'h8012;

    // reset and idle line
    #(3 * CLK_NS + 3);
    reset = 1'b1;
    repeat (10 * BIT) @(negedge clk);
    chk("rst_txd", rs232_txd, 1'b1);
    chk("rst_dbread", dbread, 1'b0);
    chk("rst_dbwrite", dbwrite, 1'b0);
    chk("rst_eadr", eadr, 5'd0);
    chk("rst_spy_out", spy_out, 16'd0);
    chk("rst_tx_extra", n_tx_extra, 0);

    // directed reads
    send_cmd(8'h80); drain("rd80");
    send_cmd(8'h81); drain("rd81");
    send_cmd(8'h92); drain("rd92");

    // nibble loads and writes
    send_cmd(8'h31); send_cmd(8'h42); send_cmd(8'h53); send_cmd(8'h64); send_cmd(8'hA2);
    drain("wrA2");
    chk("wrA2_val", spy_out, 16'h4321);
    send_cmd(8'h60); send_cmd(8'hA3);
    drain("wrA3");
    chk("wrA3_val", spy_out, 16'h0321);
    send_cmd(8'h30); send_cmd(8'h40); send_cmd(8'h50); send_cmd(8'h60); send_cmd(8'hA8);
    drain("wrA8");

    // ignored opcodes back to back
    send_cmd(8'h00); send_cmd(8'h01); send_cmd(8'h02);
    send_cmd(8'h10); send_cmd(8'h11); send_cmd(8'h12);
    drain("ignored");

    // framing error: a read command with a bad stop bit does nothing
    send_byte(8'h85, 1'b0);
    drain("framing");

    // second read waits pending behind the first
    send_cmd(8'h82); send_cmd(8'h84);
    drain("rd_pair");

    // random commands
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       b = {4'(4'h3 + r), 4'($urandom_range(0, 15))};
      else if (r < 8)  b = {4'(4'h8 + r - 4), 4'($urandom_range(0, 15))};
      else             b = {ign_ops[$urandom_range(0, 7)], 4'($urandom_range(0, 15))};
      send_cmd(b);
      if (b[7:4] == 4'h8 || b[7:4] == 4'h9) drain("rand_rd");
    end
    drain("rand_end");

    // reset in the middle of a response byte
    send_cmd(8'h3F); send_cmd(8'h5A);
    send_cmd(8'h80);
    n = 0;
    while (rs232_txd !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_tx_started", rs232_txd, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    tx_abort = 1'b1;
    reset = 1'b0;
    #1;
    chk("mid_rst_txd", rs232_txd, 1'b1);
    chk("mid_rst_dbread", dbread, 1'b0);
    chk("mid_rst_eadr", eadr, 5'd0);
    chk("mid_rst_spy_out", spy_out, 16'd0);
    exp_q.delete();
    exp_w_q.delete();
    exp_r_q.delete();
    m_spy = '0;
    m_eadr = '0;
    repeat (12 * BIT) @(negedge clk);
    reset = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("post_rst_tx_extra", n_tx_extra, 0);
    send_cmd(8'h81);
    drain("post_rst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
